// File: rtl/divisor_pkg.sv
// Shared definitions for the divider front end: state encoding, default width
// and the two's-complement magnitude helper reused by the sign-correction stage.
package divisor_pkg;

    localparam int TAMANYO_DEF = 32;

    // Widest operand the magnitude helper handles; narrower operands are sign-extended into it.
    localparam int ABS_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAPT = 3'd1,
        CONV = 3'd2,
        EMIT = 3'd3,
        ERR  = 3'd4
    } estado_t;

    // |x| for a sign-extended operand; callers truncate back to their own width,
    // which keeps the most-negative value as 2^(w-1) rather than flagging it.
    function automatic logic [ABS_MAX_W-1:0] abs_c2(input logic signed [ABS_MAX_W-1:0] x);
        logic [ABS_MAX_W-1:0] inv;
        inv = ~x;
        return x[ABS_MAX_W-1] ? (inv + ABS_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/divisor_abs.sv
// Combinational magnitude/sign split of one signed operand (tamanyo <= 64).
module divisor_abs
    import divisor_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic signed [tamanyo-1:0] valor,
    output logic        [tamanyo-1:0] magnitud,
    output logic                      signo
);

    logic signed [ABS_MAX_W-1:0] valor_ext;

    assign valor_ext = ABS_MAX_W'(valor);
    assign signo     = valor[tamanyo-1];
    assign magnitud  = tamanyo'(abs_c2(valor_ext));

endmodule

// File: rtl/divisor_preproceso.sv
// Input conditioning for the segmented divider: magnitudes, Den two's complement,
// sign flags and zero quotient seed. Define DIV_CERO_EN to reject Den==0 via Err_div0.
module divisor_preproceso
    import divisor_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic                      CLK,
    input  logic                      RSTa,
    input  logic                      Start,
    input  logic signed [tamanyo-1:0] Num,
    input  logic signed [tamanyo-1:0] Den,
    input  logic                      Hold,
    output logic                      Ready,
    output logic                      Start_out,
    output logic        [tamanyo-1:0] Q_out,
    output logic        [tamanyo-1:0] Num_c2s_out,
    output logic        [tamanyo-1:0] Den_abs_out,
    output logic        [tamanyo-1:0] Den_c2s_out,
    output logic                      Signo_Q,
    output logic                      Signo_R,
    output logic                      Err_div0
);

    estado_t state_q, state_d;

    logic signed [tamanyo-1:0] num_q, num_d;
    logic signed [tamanyo-1:0] den_q, den_d;
    logic        [tamanyo-1:0] num_abs_q, num_abs_d;
    logic        [tamanyo-1:0] den_abs_q, den_abs_d;
    logic                      sq_q, sq_d;
    logic                      sr_q, sr_d;

    logic        [tamanyo-1:0] num_out_q, num_out_d;
    logic        [tamanyo-1:0] dabs_out_q, dabs_out_d;
    logic        [tamanyo-1:0] dc2s_out_q, dc2s_out_d;
    logic                      signo_q_out_q, signo_q_out_d;
    logic                      signo_r_out_q, signo_r_out_d;

    logic        [tamanyo-1:0] num_mag, den_mag;
    logic                      num_sgn, den_sgn;
    logic                      div0;

    divisor_abs #(.tamanyo(tamanyo)) u_abs_num (
        .valor    (num_q),
        .magnitud (num_mag),
        .signo    (num_sgn)
    );

    divisor_abs #(.tamanyo(tamanyo)) u_abs_den (
        .valor    (den_q),
        .magnitud (den_mag),
        .signo    (den_sgn)
    );

`ifdef DIV_CERO_EN
    assign div0 = (den_abs_q == '0);
`else
    assign div0 = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        den_d         = den_q;
        num_abs_d     = num_abs_q;
        den_abs_d     = den_abs_q;
        sq_d          = sq_q;
        sr_d          = sr_q;
        num_out_d     = num_out_q;
        dabs_out_d    = dabs_out_q;
        dc2s_out_d    = dc2s_out_q;
        signo_q_out_d = signo_q_out_q;
        signo_r_out_d = signo_r_out_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    num_d   = Num;
                    den_d   = Den;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                num_abs_d = num_mag;
                den_abs_d = den_mag;
                sq_d      = num_sgn ^ den_sgn;
                sr_d      = num_sgn;
                state_d   = CONV;
            end
            CONV: begin
                if (div0) begin
                    state_d = ERR;
                end else begin
                    // Outputs only change here, so they stay put through Hold and between ops.
                    num_out_d     = num_abs_q;
                    dabs_out_d    = den_abs_q;
                    dc2s_out_d    = tamanyo'(~den_abs_q + tamanyo'(1));
                    signo_q_out_d = sq_q;
                    signo_r_out_d = sr_q;
                    state_d       = EMIT;
                end
            end
            EMIT: begin
                if (!Hold) state_d = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            state_q       <= IDLE;
            num_out_q     <= '0;
            dabs_out_q    <= '0;
            dc2s_out_q    <= '0;
            signo_q_out_q <= 1'b0;
            signo_r_out_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_out_q     <= num_out_d;
            dabs_out_q    <= dabs_out_d;
            dc2s_out_q    <= dc2s_out_d;
            signo_q_out_q <= signo_q_out_d;
            signo_r_out_q <= signo_r_out_d;
        end
    end

    // Working registers are never observed before being loaded, so they carry no reset.
    always_ff @(posedge CLK) begin
        num_q     <= num_d;
        den_q     <= den_d;
        num_abs_q <= num_abs_d;
        den_abs_q <= den_abs_d;
        sq_q      <= sq_d;
        sr_q      <= sr_d;
    end

    assign Ready       = (state_q == IDLE);
    assign Start_out   = (state_q == EMIT) && !Hold && !RSTa;
`ifdef DIV_CERO_EN
    assign Err_div0    = (state_q == ERR) && !RSTa;
`else
    assign Err_div0    = 1'b0;
`endif
    assign Q_out       = '0;
    assign Num_c2s_out = num_out_q;
    assign Den_abs_out = dabs_out_q;
    assign Den_c2s_out = dc2s_out_q;
    assign Signo_Q     = signo_q_out_q;
    assign Signo_R     = signo_r_out_q;

endmodule

// File: tb/tb_divisor_preproceso.sv
// Bench for divisor_preproceso at tamanyo=8: vector table with scoreboard plus reset sequences.
module tb_divisor_preproceso;

    localparam int W = 8;

    logic                CLK = 1'b0;
    logic                RSTa;
    logic                Start;
    logic signed [W-1:0] Num;
    logic signed [W-1:0] Den;
    logic                Hold;
    logic                Ready;
    logic                Start_out;
    logic        [W-1:0] Q_out;
    logic        [W-1:0] Num_c2s_out;
    logic        [W-1:0] Den_abs_out;
    logic        [W-1:0] Den_c2s_out;
    logic                Signo_Q;
    logic                Signo_R;
    logic                Err_div0;

    divisor_preproceso #(.tamanyo(W)) dut (
        .CLK         (CLK),
        .RSTa        (RSTa),
        .Start       (Start),
        .Num         (Num),
        .Den         (Den),
        .Hold        (Hold),
        .Ready       (Ready),
        .Start_out   (Start_out),
        .Q_out       (Q_out),
        .Num_c2s_out (Num_c2s_out),
        .Den_abs_out (Den_abs_out),
        .Den_c2s_out (Den_c2s_out),
        .Signo_Q     (Signo_Q),
        .Signo_R     (Signo_R),
        .Err_div0    (Err_div0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        int           hold;
        logic         err;
        logic [W-1:0] e_num;
        logic [W-1:0] e_dabs;
        logic [W-1:0] e_dc2s;
        logic         e_sq;
        logic         e_sr;
        bit           repulse;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every emit or error pulse must match the oldest pushed op.
    always begin
        vec_t e;
        @(negedge CLK);
        #2;
        if (Start_out || Err_div0) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, Start_out, Err_div0}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (Err_div0) begin
                    chk("err_expected", e.err, 1'b1);
                    chk("err_no_start", Start_out, 1'b0);
                end else begin
                    chk("emit_expected", e.err, 1'b0);
                    chk("q_out",   Q_out,       '0);
                    chk("num_c2s", Num_c2s_out, e.e_num);
                    chk("den_abs", Den_abs_out, e.e_dabs);
                    chk("den_c2s", Den_c2s_out, e.e_dc2s);
                    chk("signo_q", Signo_Q,     e.e_sq);
                    chk("signo_r", Signo_R,     e.e_sr);
                end
            end
        end
    end

    task automatic run_op(input vec_t v);
        int last;
        last = 3 + v.hold;
        @(negedge CLK);
        Start = 1'b1;
        Num   = v.num;
        Den   = v.den;
        Hold  = (v.hold > 0);
        sb.push_back(v);
        #1 chk("ready_idle", Ready, 1'b1);
        for (int c = 1; c <= last; c++) begin
            @(negedge CLK);
            if (v.repulse && c <= 2) begin
                Start = 1'b1;
                Num   = 8'h01;
                Den   = 8'h01;
            end else begin
                Start = 1'b0;
            end
            Hold = (v.hold > 0) && (c >= 2) && (c < last);
            #1;
            chk("ready_busy", Ready, 1'b0);
            chk("start_out_timing", Start_out, (!v.err && c == last));
            chk("err_timing", Err_div0, (v.err && c == 3));
            if (!v.err && c >= 3 && c < last) begin
                chk("hold_num",  Num_c2s_out, v.e_num);
                chk("hold_dabs", Den_abs_out, v.e_dabs);
                chk("hold_dc2s", Den_c2s_out, v.e_dc2s);
                chk("hold_sq",   Signo_Q,     v.e_sq);
            end
        end
        @(negedge CLK);
        Start = 1'b0;
        Hold  = 1'b0;
        #1 chk("ready_after", Ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{8'hF9, 8'h02, 0, 1'b0, 8'h07, 8'h02, 8'hFE, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h14, 8'hFB, 4, 1'b0, 8'h14, 8'h05, 8'hFB, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 0, 1'b0, 8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h0C, 8'h03, 0, 1'b0, 8'h0C, 8'h03, 8'hFD, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'h81, 0, 1'b0, 8'h7F, 8'h7F, 8'h81, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'hFF, 2, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h7F, 0, 1'b0, 8'h7F, 8'h7F, 8'h81, 1'b1, 1'b1, 1'b0});
`ifdef DIV_CERO_EN
        vecs.push_back('{8'h09, 8'h00, 0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
`else
        vecs.push_back('{8'h09, 8'h00, 0, 1'b0, 8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
`endif
        vecs.push_back('{8'hFF, 8'h01, 0, 1'b0, 8'h01, 8'h01, 8'hFF, 1'b1, 1'b1, 1'b0});

        RSTa  = 1'b1;
        Start = 1'b0;
        Num   = '0;
        Den   = '0;
        Hold  = 1'b0;
        repeat (2) @(negedge CLK);
        RSTa = 1'b0;
        #1;
        chk("rst_ready",     Ready,       1'b1);
        chk("rst_start_out", Start_out,   1'b0);
        chk("rst_err",       Err_div0,    1'b0);
        chk("rst_num",       Num_c2s_out, '0);
        chk("rst_dabs",      Den_abs_out, '0);
        chk("rst_dc2s",      Den_c2s_out, '0);
        chk("rst_sq",        Signo_Q,     1'b0);
        chk("rst_sr",        Signo_R,     1'b0);

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // Reset while the op is in CONV: nothing may be emitted and outputs clear.
        @(negedge CLK);
        Start = 1'b1;
        Num   = 8'sd12;
        Den   = 8'sd3;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        RSTa = 1'b1;
        #1 chk("midrst_no_start", Start_out, 1'b0);
        @(negedge CLK);
        RSTa = 1'b0;
        #1;
        chk("midrst_ready", Ready,       1'b1);
        chk("midrst_num",   Num_c2s_out, '0);
        chk("midrst_dabs",  Den_abs_out, '0);
        chk("midrst_dc2s",  Den_c2s_out, '0);
        chk("midrst_sq",    Signo_Q,     1'b0);
        chk("midrst_sr",    Signo_R,     1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            chk("midrst_quiet_start", Start_out, 1'b0);
            chk("midrst_quiet_err",   Err_div0,  1'b0);
        end

        // Back to normal operation after the aborted op.
        run_op('{8'hF9, 8'h02, 0, 1'b0, 8'h07, 8'h02, 8'hFE, 1'b1, 1'b1, 1'b0});

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
